processor_control_unit: RTL and testbench

Instruction-sequencing FSM for the 8-bit four-register processor. It sits directly upstream of the processor datapath and drives its control inputs: bus select, register load enables, ALU mode and G load. It fetches an 8-bit instruction from DIN when Run is asserted and steps through the timesteps that instruction needs. It pulses Done on the final step.

---
 rtl/processor_control_unit.sv | 155 +++++++++++++++
 tb/tb_processor_control_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/processor_control_unit.sv
// processor_control_unit
// Instruction-sequencing FSM for the 8-bit, four-register processor.
// Fetches an instruction from DIN when Run is high in T0, then steps through
// T1..T3 as needed, driving bus select, register/ALU load enables, ALU mode
// and a one-cycle Done pulse on the final timestep.
// Outputs are Moore-style: decoded combinationally from state and IR only.

module processor_control_unit (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic [7:0] DIN,
  output logic [5:0] S,
  output logic       R0in,
  output logic       R1in,
  output logic       R2in,
  output logic       R3in,
  output logic       Ain,
  output logic       Gin,
  output logic       Mode,
  output logic       Done,
  output logic [7:0] IR
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_MV  = 2'b00,
    OP_MVI = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } opcode_t;

  localparam logic [5:0] SEL_G   = 6'b000001;
  localparam logic [5:0] SEL_DIN = 6'b100000;

  state_t     r_state;
  logic [7:0] r_ir;

  opcode_t    w_op;
  logic [1:0] w_x;
  logic [1:0] w_y;
  logic [3:0] w_rin;
  logic [5:0] w_sel;
  logic       w_ain;
  logic       w_gin;
  logic       w_mode;
  logic       w_done;

  // One-hot bus select for a general register index.
  function automatic logic [5:0] f_reg_sel(input logic [1:0] idx);
    logic [5:0] sel;
    sel = '0;
    sel[int'(idx) + 1] = 1'b1;
    return sel;
  endfunction

  // One-hot write enable for a general register index.
  function automatic logic [3:0] f_reg_en(input logic [1:0] idx);
    logic [3:0] en;
    en = '0;
    en[idx] = 1'b1;
    return en;
  endfunction

  // IR bits [7:6] are reserved; only opcode and register fields are decoded.
  assign w_op = opcode_t'(r_ir[5:4]);
  assign w_x  = r_ir[3:2];
  assign w_y  = r_ir[1:0];

  // State sequencing and instruction fetch; reset aborts any instruction.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= T0;
      r_ir    <= '0;
    end else begin
      case (r_state)
        T0: begin
          if (Run) begin
            r_ir    <= DIN;
            r_state <= T1;
          end
        end
        T1: begin
          if (w_op == OP_ADD || w_op == OP_SUB) begin
            r_state <= T2;
          end else begin
            r_state <= T0;
          end
        end
        T2:      r_state <= T3;
        T3:      r_state <= T0;
        default: r_state <= T0;
      endcase
    end
  end

  // Control decode from current timestep and instruction.
  always_comb begin
    w_sel  = SEL_DIN;
    w_rin  = '0;
    w_ain  = 1'b0;
    w_gin  = 1'b0;
    w_mode = 1'b0;
    w_done = 1'b0;
    case (r_state)
      T1: begin
        case (w_op)
          OP_MV: begin
            w_sel  = f_reg_sel(w_y);
            w_rin  = f_reg_en(w_x);
            w_done = 1'b1;
          end
          OP_MVI: begin
            w_sel  = SEL_DIN;
            w_rin  = f_reg_en(w_x);
            w_done = 1'b1;
          end
          default: begin
            w_sel = f_reg_sel(w_x);
            w_ain = 1'b1;
          end
        endcase
      end
      T2: begin
        w_sel  = f_reg_sel(w_y);
        w_gin  = 1'b1;
        w_mode = (w_op == OP_SUB);
      end
      T3: begin
        w_sel  = SEL_G;
        w_rin  = f_reg_en(w_x);
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign S    = w_sel;
  assign R0in = w_rin[0];
  assign R1in = w_rin[1];
  assign R2in = w_rin[2];
  assign R3in = w_rin[3];
  assign Ain  = w_ain;
  assign Gin  = w_gin;
  assign Mode = w_mode;
  assign Done = w_done;
  assign IR   = r_ir;

endmodule

// File: tb/tb_processor_control_unit.sv
// Testbench for processor_control_unit: cycle-by-cycle vector table with a
// scoreboard queue, plus a small behavioural datapath driven by the DUT's
// control outputs to confirm end-to-end register results.

module tb_processor_control_unit;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Run;
  logic [7:0] DIN;
  logic [5:0] S;
  logic       R0in, R1in, R2in, R3in, Ain, Gin, Mode, Done;
  logic [7:0] IR;

  processor_control_unit dut (
    .Clk  (Clk),
    .Reset(Reset),
    .Run  (Run),
    .DIN  (DIN),
    .S    (S),
    .R0in (R0in),
    .R1in (R1in),
    .R2in (R2in),
    .R3in (R3in),
    .Ain  (Ain),
    .Gin  (Gin),
    .Mode (Mode),
    .Done (Done),
    .IR   (IR)
  );

  always #5 Clk = ~Clk;

  // Bus selects and enables ({Gin,Ain,R3in,R2in,R1in,R0in}).
  localparam logic [5:0] SD  = 6'b100000;
  localparam logic [5:0] SG  = 6'b000001;
  localparam logic [5:0] SR0 = 6'b000010;
  localparam logic [5:0] SR1 = 6'b000100;
  localparam logic [5:0] SR2 = 6'b001000;
  localparam logic [5:0] SR3 = 6'b010000;
  localparam logic [5:0] EN0 = 6'b000000;
  localparam logic [5:0] ER0 = 6'b000001;
  localparam logic [5:0] ER1 = 6'b000010;
  localparam logic [5:0] ER2 = 6'b000100;
  localparam logic [5:0] ER3 = 6'b001000;
  localparam logic [5:0] EA  = 6'b010000;
  localparam logic [5:0] EG  = 6'b100000;

  typedef struct packed {
    logic [5:0] s;
    logic [5:0] en;
    logic       mode;
    logic       done;
    logic [7:0] ir;
  } out_t;

  typedef struct packed {
    logic       rst;
    logic       run;
    logic [7:0] din;
    out_t       exp;
    logic       chk;
    logic [7:0] r3;
  } vec_t;

  vec_t vecs[$];
  out_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Behavioural datapath: registers, A and G loaded from the shared bus.
  logic [7:0] m_r [4];
  logic [7:0] m_a, m_g;
  logic [7:0] w_bus;

  always_comb begin
    case (S)
      6'b000001: w_bus = m_g;
      6'b000010: w_bus = m_r[0];
      6'b000100: w_bus = m_r[1];
      6'b001000: w_bus = m_r[2];
      6'b010000: w_bus = m_r[3];
      6'b100000: w_bus = DIN;
      default:   w_bus = 8'h00;
    endcase
  end

  always @(posedge Clk) begin
    if (R0in) m_r[0] <= w_bus;
    if (R1in) m_r[1] <= w_bus;
    if (R2in) m_r[2] <= w_bus;
    if (R3in) m_r[3] <= w_bus;
    if (Ain)  m_a    <= w_bus;
    if (Gin)  m_g    <= Mode ? (m_a - w_bus) : (m_a + w_bus);
  end

  task automatic v(input logic rst, input logic run, input logic [7:0] din,
                   input logic [5:0] s, input logic [5:0] en, input logic mode,
                   input logic done, input logic [7:0] ir,
                   input logic chk, input logic [7:0] r3);
    vec_t t;
    t.rst = rst; t.run = run; t.din = din;
    t.exp.s = s; t.exp.en = en; t.exp.mode = mode; t.exp.done = done;
    t.exp.ir = ir; t.chk = chk; t.r3 = r3;
    vecs.push_back(t);
  endtask

  out_t act;
  out_t exp;

  initial begin
    // rst run din    S    en   md dn IR     chk R3
    v(0, 0, 8'h00, SD,  EN0, 0, 0, 8'h00, 0, 8'h00); // reset state
    // mvi R0,5
    v(0, 1, 8'h10, SD,  EN0, 0, 0, 8'h00, 0, 8'h00);
    v(0, 0, 8'h05, SD,  ER0, 0, 1, 8'h10, 0, 8'h00);
    v(0, 0, 8'h00, SD,  EN0, 0, 0, 8'h10, 0, 8'h00);
    // mv R2,R1
    v(0, 1, 8'h09, SD,  EN0, 0, 0, 8'h10, 0, 8'h00);
    v(0, 0, 8'h00, SR1, ER2, 0, 1, 8'h09, 0, 8'h00);
    // add R1,R0
    v(0, 1, 8'h24, SD,  EN0, 0, 0, 8'h09, 0, 8'h00);
    v(0, 0, 8'h00, SR1, EA,  0, 0, 8'h24, 0, 8'h00);
    v(0, 0, 8'h00, SR0, EG,  0, 0, 8'h24, 0, 8'h00);
    v(0, 0, 8'h00, SG,  ER1, 0, 1, 8'h24, 0, 8'h00);
    // mvi R3,7 with Run still high during T1 (ignored there)
    v(0, 1, 8'h1C, SD,  EN0, 0, 0, 8'h24, 0, 8'h00);
    v(0, 1, 8'h07, SD,  ER3, 0, 1, 8'h1C, 0, 8'h00);
    // sub R3,R3 -> R3 = 0
    v(0, 1, 8'h3F, SD,  EN0, 0, 0, 8'h1C, 0, 8'h00);
    v(0, 1, 8'h00, SR3, EA,  0, 0, 8'h3F, 0, 8'h00);
    v(0, 1, 8'h00, SR3, EG,  1, 0, 8'h3F, 0, 8'h00);
    v(0, 0, 8'h00, SG,  ER3, 0, 1, 8'h3F, 0, 8'h00);
    v(0, 0, 8'h00, SD,  EN0, 0, 0, 8'h3F, 1, 8'h00);
    // back-to-back: mvi R0,3 / mvi R3,FE / add R3,R0 -> R3 = 01
    v(0, 1, 8'h10, SD,  EN0, 0, 0, 8'h3F, 0, 8'h00);
    v(0, 1, 8'h03, SD,  ER0, 0, 1, 8'h10, 0, 8'h00);
    v(0, 1, 8'h1C, SD,  EN0, 0, 0, 8'h10, 0, 8'h00);
    v(0, 1, 8'hFE, SD,  ER3, 0, 1, 8'h1C, 0, 8'h00);
    v(0, 1, 8'h2C, SD,  EN0, 0, 0, 8'h1C, 0, 8'h00);
    v(0, 1, 8'h00, SR3, EA,  0, 0, 8'h2C, 0, 8'h00);
    v(0, 1, 8'h00, SR0, EG,  0, 0, 8'h2C, 0, 8'h00);
    v(0, 0, 8'h00, SG,  ER3, 0, 1, 8'h2C, 0, 8'h00);
    v(0, 0, 8'h00, SD,  EN0, 0, 0, 8'h2C, 1, 8'h01);
    // reset during T2 of add R1,R0 with Run high
    v(0, 1, 8'h24, SD,  EN0, 0, 0, 8'h2C, 0, 8'h00);
    v(0, 1, 8'h24, SR1, EA,  0, 0, 8'h24, 0, 8'h00);
    v(1, 1, 8'h24, SR0, EG,  0, 0, 8'h24, 0, 8'h00);
    v(0, 0, 8'h24, SD,  EN0, 0, 0, 8'h00, 0, 8'h00);
    // reserved bits set: 8'hC6 decodes as mv R1,R2
    v(0, 1, 8'hC6, SD,  EN0, 0, 0, 8'h00, 0, 8'h00);
    v(0, 0, 8'h00, SR2, ER1, 0, 1, 8'hC6, 0, 8'h00);
    v(0, 0, 8'h00, SD,  EN0, 0, 0, 8'hC6, 0, 8'h00);

    Reset = 1'b1;
    Run   = 1'b0;
    DIN   = 8'h00;
    @(posedge Clk);
    #1;

    foreach (vecs[i]) begin
      Reset = vecs[i].rst;
      Run   = vecs[i].run;
      DIN   = vecs[i].din;
      sb.push_back(vecs[i].exp);
      @(negedge Clk);
      act = '{s: S, en: {Gin, Ain, R3in, R2in, R1in, R0in}, mode: Mode,
              done: Done, ir: IR};
      exp = sb.pop_front();
      n_cmp++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL vec%0d outputs: got S=%b en=%b mode=%b done=%b IR=%h, want S=%b en=%b mode=%b done=%b IR=%h",
                 i, act.s, act.en, act.mode, act.done, act.ir,
                 exp.s, exp.en, exp.mode, exp.done, exp.ir);
      end
      if (vecs[i].chk) begin
        n_cmp++;
        if (m_r[3] !== vecs[i].r3) begin
          n_err++;
          $display("FAIL vec%0d datapath R3: got %h, want %h", i, m_r[3], vecs[i].r3);
        end
      end
      @(posedge Clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
